// File: rtl/cgra_stream_pkg.sv
// Shared widths, state encoding and data typedefs for the CGRA stream adapters.
package cgra_stream_pkg;

    localparam int CGRA_LINE_W         = 512;
    localparam int CGRA_WORD_W         = 32;
    localparam int CGRA_WORDS_PER_LINE = CGRA_LINE_W / CGRA_WORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } t_unpack_state;

    typedef logic [CGRA_LINE_W-1:0] t_cgra_line;
    typedef logic [CGRA_WORD_W-1:0] t_cgra_word;

endpackage

// File: rtl/cgra_line_fifo.sv
// Registered line FIFO with write, pop and flush; head entry is always visible.
// A write into a full FIFO succeeds when the head pops in the same cycle; flush wins over both.
module cgra_line_fifo #(
    parameter int W     = 512,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          wr_ok, pop_ok;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ok  = wr_i && (!full_o || pop_i) && !flush_i;
    assign pop_ok = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_ok)  wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/cgra_line_unpacker.sv
// Serialises buffered 512-bit host lines into 32-bit CGRA words for a counted job.
// Define CGRA_UNPACK_STALL_CNT_EN to build the saturating backpressure stall counter.
module cgra_line_unpacker
    import cgra_stream_pkg::*;
#(
    parameter int LINE_W    = CGRA_LINE_W,
    parameter int WORD_W    = CGRA_WORD_W,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       word_count,
    input  logic [LINE_W-1:0] line_in,
    input  logic              line_valid,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              almost_full,
    output logic              overflow,
    output logic              done,
    output logic              busy,
    output logic [31:0]       stall_cnt
);

    localparam int WPL = LINE_W / WORD_W;
    localparam int SW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] AF_T = CW'(AF_THRESH);

    t_unpack_state state_q, state_d;
    logic [31:0]   target_q, target_d;
    logic [31:0]   emitted_q, emitted_d;
    logic [SW-1:0] slice_q, slice_d;
    logic          ovf_q, ovf_d;

    logic [LINE_W-1:0] head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              hs, pop, enter_done, accept, drop;

    assign word_valid  = (state_q == RUN) && !fifo_empty;
    assign hs          = word_valid && word_ready;
    assign pop         = hs && (slice_q == SW'(WPL - 1));
    assign accept      = (state_q == IDLE) && start;
    // A write colliding with the DONE flush is discarded silently, not counted as a drop.
    assign drop        = line_valid && fifo_full && !pop && !enter_done;

    assign word_out    = head[slice_q*WORD_W +: WORD_W];
    assign almost_full = (fifo_count >= AF_T);
    assign overflow    = ovf_q;
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);

    cgra_line_fifo #(
        .W     (LINE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_i      (line_valid),
        .wr_data_i (line_in),
        .pop_i     (pop),
        .flush_i   (enter_done),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        emitted_d  = emitted_q;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d  = word_count;
                    emitted_d = '0;
                    if (word_count == '0) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    emitted_d = emitted_q + 32'd1;
                    if (emitted_q + 32'd1 == target_q) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slice_d = slice_q;
        if (enter_done || pop) slice_d = '0;
        else if (hs)           slice_d = slice_q + 1'b1;
    end

    always_comb begin
        ovf_d = ovf_q;
        if (accept) ovf_d = 1'b0;
        if (drop)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            emitted_q <= '0;
            slice_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            emitted_q <= emitted_d;
            slice_q   <= slice_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef CGRA_UNPACK_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept)                                              stall_d = '0;
        else if (word_valid && !word_ready && (stall_q != '1))   stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
